// File: rtl/blue_noise_dither_stream.sv
// Streaming blue-noise dither: quantises PIXELS 8-bit pixels per beat to OUTPUT_BITS each,
// using a runtime-loaded 64x64 signed noise tile with an optional per-frame offset.
module blue_noise_dither_stream #(
  parameter int unsigned PIXELS      = 4,
  parameter int unsigned OUTPUT_BITS = 1,
  parameter int unsigned NOISE_ATTEN = 0,
  parameter int unsigned STEP_X      = 17,
  parameter int unsigned STEP_Y      = 23
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [PIXELS*8-1:0]             s_data,
  input  logic                            s_sof,
  input  logic                            s_eol,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [PIXELS*OUTPUT_BITS-1:0]   m_data,
  input  logic                            dither_en,
  input  logic                            temporal_en,
  input  logic                            nz_we,
  input  logic [11:0]                     nz_addr,
  input  logic [7:0]                      nz_wdata
);

  localparam int unsigned DW    = PIXELS * 8;
  localparam int unsigned DEPTH = 4096 / PIXELS;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned COLS  = 64 / PIXELS;
  localparam int unsigned RW    = (PIXELS > 1) ? $clog2(PIXELS) : 1;

  logic          s1_adv, s2_adv, accept;
  logic          s1_valid_q, s1_dith_q;
  logic [DW-1:0] s1_data_q;
  logic [5:0]    s1_ax_q, s1_ay_q;
  logic          s2_valid_q, s2_dith_q;
  logic [DW-1:0] s2_data_q;
  logic [RW-1:0] s2_rot_q;

  logic [5:0] x_q, x_d, y_q, y_d;
  logic [5:0] offx_q, offx_d, offy_q, offy_d;
  logic [5:0] nxtx_q, nxtx_d, nxty_q, nxty_d;
  logic [5:0] bx, by, box, boy;

  logic [PIXELS-1:0][AW-1:0] rd_addr;
  logic [PIXELS-1:0][7:0]    rd_data;
  logic [AW-1:0]             widx;
  logic [RW-1:0]             wbank;

  logic [7:0]        nz_v, a_v, c_v;
  logic signed [9:0] n_s, sum_s;

  assign s2_adv  = !s2_valid_q || m_ready;
  assign s1_adv  = s2_adv;
  assign s_ready = !s1_valid_q || s1_adv;
  assign accept  = s_valid && s_ready;
  assign m_valid = s2_valid_q;

  // Beat coordinates/offsets and their post-beat update; an sof beat starts at the origin.
  always_comb begin
    bx     = s_sof ? 6'd0 : x_q;
    by     = s_sof ? 6'd0 : y_q;
    box    = 6'd0;
    boy    = 6'd0;
    x_d    = x_q;
    y_d    = y_q;
    offx_d = offx_q;
    offy_d = offy_q;
    nxtx_d = nxtx_q;
    nxty_d = nxty_q;
    if (temporal_en) begin
      box = s_sof ? nxtx_q : offx_q;
      boy = s_sof ? nxty_q : offy_q;
    end
    if (accept) begin
      if (s_eol) begin
        x_d = 6'd0;
        y_d = by + 6'd1;
      end else begin
        x_d = bx + 6'(PIXELS);
        y_d = by;
      end
      if (temporal_en && s_sof) begin
        offx_d = nxtx_q;
        offy_d = nxty_q;
        nxtx_d = nxtx_q + 6'(STEP_X);
        nxty_d = nxty_q + 6'(STEP_Y);
      end
    end
    if (!temporal_en) begin
      offx_d = 6'd0;
      offy_d = 6'd0;
      nxtx_d = 6'd0;
      nxty_d = 6'd0;
    end
  end

  // Bank b serves whichever pixel of the beat lands on column b mod PIXELS.
  always_comb begin
    rd_addr = '0;
    for (int unsigned b = 0; b < PIXELS; b++) begin
      rd_addr[RW'(b)] = AW'(32'(s1_ay_q) * COLS +
                        ((32'(s1_ax_q) + (b + PIXELS - 32'(s1_ax_q) % PIXELS) % PIXELS) % 64)
                        / PIXELS);
    end
  end

  assign wbank = RW'(32'(nz_addr[5:0]) % PIXELS);
  assign widx  = AW'(32'(nz_addr[11:6]) * COLS + 32'(nz_addr[5:0]) / PIXELS);

  for (genvar b = 0; b < PIXELS; b++) begin : g_bank
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (nz_we && wbank == RW'(b)) mem[widx] <= nz_wdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)       rd_q <= '0;
      else if (s1_adv) rd_q <= mem[rd_addr[b]];
    end

    assign rd_data[b] = rd_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_dith_q  <= 1'b0;
      s1_data_q  <= '0;
      s1_ax_q    <= '0;
      s1_ay_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_dith_q  <= 1'b0;
      s2_data_q  <= '0;
      s2_rot_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      offx_q     <= '0;
      offy_q     <= '0;
      nxtx_q     <= '0;
      nxty_q     <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      offx_q <= offx_d;
      offy_q <= offy_d;
      nxtx_q <= nxtx_d;
      nxty_q <= nxty_d;
      if (s_ready) begin
        s1_valid_q <= s_valid;
        if (s_valid) begin
          s1_data_q <= s_data;
          s1_ax_q   <= bx + box;
          s1_ay_q   <= by + boy;
          s1_dith_q <= dither_en;
        end
      end
      if (s1_adv) begin
        s2_valid_q <= s1_valid_q;
        s2_data_q  <= s1_data_q;
        s2_rot_q   <= RW'(32'(s1_ax_q) % PIXELS);
        s2_dith_q  <= s1_dith_q;
      end
    end
  end

  // Saturating add of attenuated noise, then keep the top OUTPUT_BITS.
  always_comb begin
    m_data = '0;
    nz_v   = '0;
    a_v    = '0;
    c_v    = '0;
    n_s    = '0;
    sum_s  = '0;
    for (int unsigned i = 0; i < PIXELS; i++) begin
      nz_v  = rd_data[RW'((i + 32'(s2_rot_q)) % PIXELS)];
      a_v   = s2_data_q[(PIXELS-1-i)*8 +: 8];
      n_s   = s2_dith_q ? ($signed({{2{nz_v[7]}}, nz_v}) >>> NOISE_ATTEN) : 10'sd0;
      sum_s = $signed({2'b00, a_v}) + n_s;
      if (sum_s < 10'sd0)        c_v = 8'h00;
      else if (sum_s > 10'sd255) c_v = 8'hFF;
      else                       c_v = sum_s[7:0];
      m_data[(PIXELS-1-i)*OUTPUT_BITS +: OUTPUT_BITS] = c_v[7 -: OUTPUT_BITS];
    end
  end

endmodule

// File: tb/tb_blue_noise_dither_stream.sv
// Bench for blue_noise_dither_stream: directed cases plus randomized backpressure
// against a tile/coordinate reference model.
module tb_blue_noise_dither_stream;

  localparam int unsigned P   = 4;
  localparam int unsigned OB  = 1;
  localparam int unsigned ATT = 0;
  localparam int unsigned SX  = 17;
  localparam int unsigned SY  = 23;
  localparam int unsigned DW  = P * 8;
  localparam int unsigned OW  = P * OB;
  localparam int NB = 1000;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          s_valid = 1'b0, s_sof = 1'b0, s_eol = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [OW-1:0] m_data;
  logic          dither_en = 1'b1, temporal_en = 1'b0, nz_we = 1'b0;
  logic [11:0]   nz_addr = '0;
  logic [7:0]    nz_wdata = '0;

  blue_noise_dither_stream #(
    .PIXELS(P), .OUTPUT_BITS(OB), .NOISE_ATTEN(ATT), .STEP_X(SX), .STEP_Y(SY)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .dither_en(dither_en), .temporal_en(temporal_en),
    .nz_we(nz_we), .nz_addr(nz_addr), .nz_wdata(nz_wdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]    nz_mem [4096];
  int            mx = 0, my = 0, mk = 0, cf = 0;
  logic [OW-1:0] sb_q [$];

  // Reference: address the tile by screen coordinate plus frame offset, add, clamp, truncate.
  function automatic logic [OW-1:0] model_out(logic [DW-1:0] d, int x, int y, int ox, int oy,
                                              logic dith);
    logic [OW-1:0] r;
    r = '0;
    for (int i = 0; i < P; i++) begin
      int a, n, c;
      logic [7:0] v;
      a = int'(d[(P-1-i)*8 +: 8]);
      v = nz_mem[((y + oy) % 64) * 64 + (x + i + ox) % 64];
      n = v[7] ? int'(v) - 256 : int'(v);
      n = dith ? (n >>> ATT) : 0;
      c = a + n;
      if (c < 0) c = 0;
      if (c > 255) c = 255;
      r[(P-1-i)*OB +: OB] = OB'(c >> (8 - OB));
    end
    return r;
  endfunction

  function automatic logic [OW-1:0] model_accept(logic [DW-1:0] d, logic sof, logic eol);
    int bx, by, ox, oy;
    logic [OW-1:0] r;
    if (!temporal_en) begin
      mk = 0;
      cf = 0;
    end else if (sof) begin
      cf = mk;
      mk = mk + 1;
    end
    bx = sof ? 0 : mx;
    by = sof ? 0 : my;
    ox = temporal_en ? (cf * int'(SX)) % 64 : 0;
    oy = temporal_en ? (cf * int'(SY)) % 64 : 0;
    r  = model_out(d, bx, by, ox, oy, dither_en);
    if (eol) begin
      mx = 0;
      my = (by + 1) % 64;
    end else begin
      mx = (bx + int'(P)) % 64;
      my = by;
    end
    return r;
  endfunction

  task automatic set_temporal(input logic v);
    temporal_en = v;
    if (!v) begin
      mk = 0;
      cf = 0;
    end
  endtask

  task automatic write_noise(input int addr, input logic [7:0] v);
    nz_we = 1'b1; nz_addr = 12'(addr); nz_wdata = v;
    nz_mem[addr] = v;
    @(posedge clk); #1;
    nz_we = 1'b0;
  endtask

  task automatic load_all(input logic rnd);
    for (int a = 0; a < 4096; a++) begin
      nz_we = 1'b1; nz_addr = 12'(a);
      nz_wdata = rnd ? 8'($urandom) : 8'h00;
      nz_mem[a] = nz_wdata;
      @(posedge clk); #1;
    end
    nz_we = 1'b0;
  endtask

  task automatic do_beat(input logic [DW-1:0] d, input logic sof, input logic eol,
                         output logic [OW-1:0] got, output logic [OW-1:0] expv, output int lat);
    logic acc;
    acc = 1'b0; got = '0; expv = '0; lat = -1;
    m_ready = 1'b1; s_valid = 1'b1; s_data = d; s_sof = sof; s_eol = eol;
    for (int c = 0; c < 10 && !acc; c++) begin
      @(negedge clk);
      if (s_ready) begin
        acc  = 1'b1;
        expv = model_accept(d, sof, eol);
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      @(negedge clk);
      if (acc && m_valid) begin
        lat = c;
        got = m_data;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (s_ready !== 1'b1) begin n_errors++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
    n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    n_checks++; if (m_data !== '0) begin n_errors++; $display("FAIL reset_m_data: got %h expected 0", m_data); end
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ramp;
    logic [OW-1:0] g, e;
    int lat;
    load_all(1'b0);
    dither_en = 1'b1;
    set_temporal(1'b0);
    do_beat(32'h807FFF00, 1'b1, 1'b0, g, e, lat);
    n_checks++; if (g !== 4'b1010) begin n_errors++; $display("FAIL ramp_data: got %b expected 1010", g); end
    n_checks++; if (lat !== 2) begin n_errors++; $display("FAIL ramp_latency: got %0d expected 2", lat); end
    n_checks++; if (g !== e) begin n_errors++; $display("FAIL ramp_model: got %b expected %b", g, e); end
  endtask

  task automatic test_saturation;
    logic [OW-1:0] g, e;
    int lat;
    write_noise(0, 8'h7F);
    do_beat(32'hC0000000, 1'b1, 1'b0, g, e, lat);
    n_checks++; if (g !== 4'b1000) begin n_errors++; $display("FAIL sat_c0: got %b expected 1000", g); end
    do_beat(32'h40000000, 1'b1, 1'b1, g, e, lat);
    n_checks++; if (g !== 4'b1000) begin n_errors++; $display("FAIL sat_40_dither: got %b expected 1000", g); end
    dither_en = 1'b0;
    do_beat(32'h40000000, 1'b1, 1'b1, g, e, lat);
    n_checks++; if (g !== 4'b0000) begin n_errors++; $display("FAIL sat_40_plain: got %b expected 0000", g); end
    dither_en = 1'b1;
  endtask

  task automatic test_negative;
    logic [OW-1:0] g, e;
    int lat;
    write_noise(0, 8'h80);
    do_beat(32'h10909090, 1'b1, 1'b0, g, e, lat);
    n_checks++; if (g !== 4'b0111) begin n_errors++; $display("FAIL neg_clamp: got %b expected 0111", g); end
    do_beat(32'h90909090, 1'b1, 1'b0, g, e, lat);
    n_checks++; if (g !== 4'b0111) begin n_errors++; $display("FAIL neg_sub: got %b expected 0111", g); end
    dither_en = 1'b0;
    do_beat(32'h10909090, 1'b1, 1'b0, g, e, lat);
    n_checks++; if (g !== 4'b0111) begin n_errors++; $display("FAIL neg_plain: got %b expected 0111", g); end
    dither_en = 1'b1;
  endtask

  task automatic test_coords_temporal;
    logic [OW-1:0] g, e;
    int lat;
    load_all(1'b0);
    write_noise(23 * 64 + 17, 8'h7F);
    set_temporal(1'b1);
    do_beat(32'h10101010, 1'b1, 1'b0, g, e, lat);
    n_checks++; if (g !== 4'b0000) begin n_errors++; $display("FAIL frame0: got %b expected 0000", g); end
    do_beat(32'h10101010, 1'b1, 1'b0, g, e, lat);
    n_checks++; if (g !== 4'b1000) begin n_errors++; $display("FAIL frame1: got %b expected 1000", g); end
    set_temporal(1'b0);
    do_beat(32'h10101010, 1'b1, 1'b0, g, e, lat);
    n_checks++; if (g !== 4'b0000) begin n_errors++; $display("FAIL frame1_notemp: got %b expected 0000", g); end
    write_noise(4, 8'h7F);
    write_noise(64, 8'h7F);
    do_beat(32'h10101010, 1'b1, 1'b0, g, e, lat);
    n_checks++; if (g !== 4'b0000) begin n_errors++; $display("FAIL coord_x0: got %b expected 0000", g); end
    do_beat(32'h10101010, 1'b0, 1'b1, g, e, lat);
    n_checks++; if (g !== 4'b1000) begin n_errors++; $display("FAIL coord_x4: got %b expected 1000", g); end
    do_beat(32'h10101010, 1'b0, 1'b0, g, e, lat);
    n_checks++; if (g !== 4'b1000) begin n_errors++; $display("FAIL coord_eol_wrap: got %b expected 1000", g); end
    do_beat(32'h10101010, 1'b1, 1'b1, g, e, lat);
    n_checks++; if (g !== 4'b0000) begin n_errors++; $display("FAIL coord_sof_eol: got %b expected 0000", g); end
    do_beat(32'h10101010, 1'b0, 1'b0, g, e, lat);
    n_checks++; if (g !== 4'b1000) begin n_errors++; $display("FAIL coord_single_line: got %b expected 1000", g); end
  endtask

  task automatic test_fill;
    int acc, popped;
    logic [OW-1:0] first, e;
    logic have;
    acc = 0; popped = 0; have = 1'b0; first = '0;
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = DW'($urandom); s_sof = 1'b1; s_eol = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m_valid && !have) begin have = 1'b1; first = m_data; end
      if (s_valid && s_ready) begin
        sb_q.push_back(model_accept(s_data, s_sof, s_eol));
        acc++;
        @(posedge clk); #1;
        s_data = DW'($urandom); s_sof = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    n_checks++; if (acc !== 2) begin n_errors++; $display("FAIL fill_absorbed: got %0d expected 2", acc); end
    n_checks++; if (s_ready !== 1'b0) begin n_errors++; $display("FAIL fill_s_ready: got %b expected 0", s_ready); end
    n_checks++; if (m_data !== first) begin n_errors++; $display("FAIL fill_stable: got %b expected %b", m_data, first); end
    s_valid = 1'b0; s_sof = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m_valid) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++; $display("FAIL fill_extra: got %b expected none", m_data);
        end else begin
          e = sb_q.pop_front();
          if (m_data !== e) begin n_errors++; $display("FAIL fill_drain: got %b expected %b", m_data, e); end
        end
        popped++;
      end
      @(posedge clk); #1;
    end
    n_checks++; if (popped !== 2) begin n_errors++; $display("FAIL fill_count: got %0d expected 2", popped); end
  endtask

  task automatic test_back_to_back;
    int sent, got, cyc;
    logic stalled, held;
    logic [OW-1:0] prev, e;
    sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = 1'b0; prev = '0;
    load_all(1'b1);
    set_temporal(1'b0);
    @(posedge clk); #1;
    set_temporal(1'b1);
    while ((sent < NB || sb_q.size() != 0) && cyc < 20000) begin
      if (!held) begin
        if (sent < NB && $urandom_range(9) < 7) begin
          s_valid = 1'b1; s_data = DW'({$urandom, $urandom});
          s_sof = ($urandom_range(19) == 0); s_eol = ($urandom_range(5) == 0);
          dither_en = ($urandom_range(9) != 0);
        end else begin
          s_valid = 1'b0;
        end
      end
      m_ready = ($urandom_range(2) != 0);
      @(negedge clk);
      if (m_valid && stalled) begin
        n_checks++;
        if (m_data !== prev) begin n_errors++; $display("FAIL b2b_stable: got %b expected %b", m_data, prev); end
      end
      if (m_valid && m_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++; $display("FAIL b2b_extra: got %b expected none", m_data);
        end else begin
          e = sb_q.pop_front();
          if (m_data !== e) begin n_errors++; $display("FAIL b2b_data: beat %0d got %b expected %b", got, m_data, e); end
        end
        got++;
      end
      stalled = m_valid && !m_ready;
      prev = m_data;
      if (s_valid && s_ready) begin
        sb_q.push_back(model_accept(s_data, s_sof, s_eol));
        sent++;
        held = 1'b0;
      end else begin
        held = s_valid;
      end
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; m_ready = 1'b1; dither_en = 1'b1;
    n_checks++; if (got !== NB) begin n_errors++; $display("FAIL b2b_count: got %0d expected %0d", got, NB); end
  endtask

  task automatic test_reset_midstream;
    int acc, seen;
    logic [OW-1:0] g, e;
    int lat;
    acc = 0; seen = 0;
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = DW'($urandom); s_sof = 1'b0; s_eol = 1'b0;
    for (int c = 0; c < 10 && acc < 2; c++) begin
      @(negedge clk);
      if (s_ready) begin
        e = model_accept(s_data, s_sof, s_eol);
        acc++;
      end
      @(posedge clk); #1;
      s_data = DW'($urandom);
    end
    s_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_m_valid: got %b expected 0", m_valid); end
    n_checks++; if (s_ready !== 1'b1) begin n_errors++; $display("FAIL rst_mid_s_ready: got %b expected 1", s_ready); end
    sb_q.delete();
    mx = 0; my = 0; mk = 0; cf = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (m_valid) seen++;
      @(posedge clk); #1;
    end
    n_checks++; if (seen !== 0) begin n_errors++; $display("FAIL rst_mid_ghost: got %0d beats expected 0", seen); end
    do_beat(DW'($urandom), 1'b0, 1'b0, g, e, lat);
    n_checks++; if (g !== e) begin n_errors++; $display("FAIL rst_mid_coord: got %b expected %b", g, e); end
    do_beat(DW'($urandom), 1'b1, 1'b0, g, e, lat);
    n_checks++; if (g !== e) begin n_errors++; $display("FAIL rst_mid_sof_off: got %b expected %b", g, e); end
    do_beat(DW'($urandom), 1'b0, 1'b1, g, e, lat);
    n_checks++; if (g !== e) begin n_errors++; $display("FAIL rst_mid_next: got %b expected %b", g, e); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_saturation();
    test_negative();
    test_coords_temporal();
    test_fill();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
